// File: rtl/fa_self_checker.sv
`default_nettype none
// ============================================================================
// Module      : fa_self_checker
// Description : Drives all eight {A,B,Cin} vectors into an external full adder,
//               compares S/Cout after a settle window and records mismatches.
// Revision    : 1.0  initial release
// ============================================================================
module fa_self_checker #(
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       A,
   output logic       B,
   output logic       Cin,
   input  logic       S,
   input  logic       Cout,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] err_count,
   output logic [7:0] fail_vec
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [3:0] c_settle_last = 4'(SETTLE_CYCLES - 1);
   localparam logic [3:0] c_err_max     = 4'd8;

   state_t      state_q, state_d;
   logic [2:0]  idx_q, idx_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [3:0]  err_q, err_d;
   logic [7:0]  fail_q, fail_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   logic        active;
   logic        accept;
   logic        exp_s;
   logic        exp_c;
   logic        mismatch;

   assign active   = (state_q == WAIT) || (state_q == CHECK);
   assign {A, B, Cin} = active ? idx_q : 3'b000;
   assign exp_s    = ^idx_q;
   assign exp_c    = (idx_q[2] & idx_q[1]) | (idx_q[2] & idx_q[0]) | (idx_q[1] & idx_q[0]);
   assign mismatch = (S != exp_s) || (Cout != exp_c);
   // busy lags the state by one edge, so the DONE-entry cycle still blocks start
   assign accept   = start && !busy_q && !active;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      fail_d  = fail_q;
      busy_d  = active;
      done_d  = (state_q == DONE) && !accept;

      case (state_q)
         IDLE, DONE: begin
            if (accept) begin
               state_d = WAIT;
               idx_d   = 3'd0;
               cnt_d   = 4'd0;
               err_d   = 4'd0;
               fail_d  = 8'h00;
            end
         end
         WAIT: begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == c_settle_last) begin
               state_d = CHECK;
            end
         end
         CHECK: begin
            if (mismatch) begin
               if (err_q < c_err_max) begin
                  err_d = err_q + 4'd1;
               end
               fail_d[idx_q] = 1'b1;
            end
            if (idx_q == 3'd7) begin
               state_d = DONE;
            end else begin
               idx_d   = idx_q + 3'd1;
               cnt_d   = 4'd0;
               state_d = WAIT;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= 3'd0;
         cnt_q   <= 4'd0;
         err_q   <= 4'd0;
         fail_q  <= 8'h00;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         fail_q  <= fail_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = done_q && (err_q == 4'd0);
   assign err_count = err_q;
   assign fail_vec  = fail_q;

endmodule
`default_nettype wire

// File: tb/tb_fa_self_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_fa_self_checker
// Description : Directed bench for fa_self_checker with a fault-injectable FA.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fa_self_checker;

   logic       clk;
   logic       rst;
   logic       start;
   logic       A, B, Cin, S, Cout;
   logic       busy, done, pass;
   logic [3:0] err_count;
   logic [7:0] fail_vec;

   logic       start2;
   logic       A2, B2, Cin2, S2, Cout2;
   logic       busy2, done2, pass2;
   logic [3:0] err_count2;
   logic [7:0] fail_vec2;

   int fault;
   int total;
   int bad;

   // fault: 0 good, 1 Cout stuck 0, 2 S inverted, 3 Cout inverted
   assign S    = (A ^ B ^ Cin) ^ (fault == 2);
   assign Cout = (fault == 1) ? 1'b0 : (((A & B) | (A & Cin) | (B & Cin)) ^ (fault == 3));
   assign S2   = A2 ^ B2 ^ Cin2;
   assign Cout2 = (A2 & B2) | (A2 & Cin2) | (B2 & Cin2);

   fa_self_checker #(.SETTLE_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .start(start),
      .A(A), .B(B), .Cin(Cin), .S(S), .Cout(Cout),
      .busy(busy), .done(done), .pass(pass),
      .err_count(err_count), .fail_vec(fail_vec)
   );

   fa_self_checker #(.SETTLE_CYCLES(1)) dut1 (
      .clk(clk), .rst(rst), .start(start2),
      .A(A2), .B(B2), .Cin(Cin2), .S(S2), .Cout(Cout2),
      .busy(busy2), .done(done2), .pass(pass2),
      .err_count(err_count2), .fail_vec(fail_vec2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      int         mode;
      int         pulse_e;
      logic [3:0] err;
      logic [7:0] fail;
      logic       pass;
   } run_t;

   run_t tbl[5];

   // One full run: start sampled at edge 0, optional extra start pulse sampled at pulse_e+1
   task automatic run_seq(input int idx, input run_t r);
      fault = r.mode;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk($sformatf("run%0d clear err", idx), 32'(err_count), 0);
      chk($sformatf("run%0d clear fail", idx), 32'(fail_vec), 0);
      chk($sformatf("run%0d clear pass", idx), 32'(pass), 0);
      for (int e = 0; e <= 25; e++) begin
         if (e > 0) begin
            @(posedge clk);
            #1;
            start = 1'b0;
         end
         chk($sformatf("run%0d vec e%0d", idx, e), 32'({A, B, Cin}), (e <= 23) ? e / 3 : 0);
         chk($sformatf("run%0d busy e%0d", idx, e), 32'(busy), (e >= 1 && e <= 24) ? 1 : 0);
         chk($sformatf("run%0d done e%0d", idx, e), 32'(done), (e >= 25) ? 1 : 0);
         if (e == r.pulse_e) start = 1'b1;
      end
      chk($sformatf("run%0d err_count", idx), 32'(err_count), 32'(r.err));
      chk($sformatf("run%0d fail_vec", idx), 32'(fail_vec), 32'(r.fail));
      chk($sformatf("run%0d pass", idx), 32'(pass), 32'(r.pass));
      @(posedge clk);
      #1;
      chk($sformatf("run%0d hold err", idx), 32'(err_count), 32'(r.err));
      chk($sformatf("run%0d hold done", idx), 32'(done), 1);
   endtask

   initial begin
      total  = 0;
      bad    = 0;
      fault  = 0;
      rst    = 1'b1;
      start  = 1'b0;
      start2 = 1'b0;

      tbl[0] = '{mode: 0, pulse_e: -1, err: 4'd0, fail: 8'h00, pass: 1'b1};
      tbl[1] = '{mode: 1, pulse_e: 9,  err: 4'd4, fail: 8'hE8, pass: 1'b0};
      tbl[2] = '{mode: 0, pulse_e: 24, err: 4'd0, fail: 8'h00, pass: 1'b1};
      tbl[3] = '{mode: 2, pulse_e: -1, err: 4'd8, fail: 8'hFF, pass: 1'b0};
      tbl[4] = '{mode: 3, pulse_e: 13, err: 4'd8, fail: 8'hFF, pass: 1'b0};

      #12;
      chk("reset vec", 32'({A, B, Cin}), 0);
      chk("reset busy", 32'(busy), 0);
      chk("reset done", 32'(done), 0);
      chk("reset pass", 32'(pass), 0);
      chk("reset err", 32'(err_count), 0);
      chk("reset fail", 32'(fail_vec), 0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 5; i++) begin
         run_seq(i, tbl[i]);
      end

      // Asynchronous reset during vector 4 with errors already recorded
      fault = 2;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (13) @(posedge clk);
      #1;
      chk("pre-rst vec", 32'({A, B, Cin}), 3'b100);
      chk("pre-rst err", 32'(err_count), 4);
      chk("pre-rst fail", 32'(fail_vec), 8'h0F);
      #2;
      rst = 1'b1;
      #1;
      chk("async rst vec", 32'({A, B, Cin}), 0);
      chk("async rst busy", 32'(busy), 0);
      chk("async rst err", 32'(err_count), 0);
      chk("async rst fail", 32'(fail_vec), 0);
      chk("async rst done", 32'(done), 0);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk);
         #1;
         chk($sformatf("idle c%0d busy", c), 32'(busy), 0);
         chk($sformatf("idle c%0d vec", c), 32'({A, B, Cin}), 0);
         chk($sformatf("idle c%0d done", c), 32'(done), 0);
      end

      // start held through reset only takes effect at the first edge after release
      fault = 0;
      @(negedge clk);
      rst   = 1'b1;
      start = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst+start busy", 32'(busy), 0);
      chk("rst+start vec", 32'({A, B, Cin}), 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      chk("post-rst start busy e1", 32'(busy), 1);
      repeat (23) @(posedge clk);
      #1;
      chk("post-rst done e24", 32'(done), 0);
      @(posedge clk);
      #1;
      chk("post-rst done e25", 32'(done), 1);
      chk("post-rst pass", 32'(pass), 1);

      // SETTLE_CYCLES=1 instance
      @(negedge clk);
      start2 = 1'b1;
      @(posedge clk);
      #1;
      start2 = 1'b0;
      for (int e = 0; e <= 17; e++) begin
         if (e > 0) begin
            @(posedge clk);
            #1;
         end
         chk($sformatf("s1 vec e%0d", e), 32'({A2, B2, Cin2}), (e <= 15) ? e / 2 : 0);
         chk($sformatf("s1 done e%0d", e), 32'(done2), (e >= 17) ? 1 : 0);
         chk($sformatf("s1 busy e%0d", e), 32'(busy2), (e >= 1 && e <= 16) ? 1 : 0);
      end
      chk("s1 pass", 32'(pass2), 1);
      chk("s1 err", 32'(err_count2), 0);
      chk("s1 fail", 32'(fail_vec2), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
